// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer: fills one bank in natural order while the other
// bank drains in bit-reversed address order, sustaining one word per cycle.
module fft_reorder_buf #(
    parameter int DATA_W = 136,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    // Handshakes: a word moves on any rising edge where valid && ready are
    // both high; a producer holding valid keeps its data stable until ready.
    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [ADDR_W-1:0] wi_q, wi_d;
    logic [ADDR_W-1:0] ri_q, ri_d;
    logic [ADDR_W-1:0] ri_rev;
    logic              wr_en, rd_en;

    always_comb begin
        ri_rev = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            ri_rev[b] = ri_q[ADDR_W-1-b];
        end
    end

    assign in_ready  = !full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign out_data  = mem_q[rb_q][ri_rev];
    assign out_last  = out_valid && (ri_q == LAST_IDX);

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    // Write and read always target different banks, so both updates may apply.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wi_d   = wi_q;
        ri_d   = ri_q;
        if (wr_en) begin
            if (wi_q == LAST_IDX) begin
                full_d[wb_q] = 1'b1;
                wi_d         = '0;
                wb_d         = !wb_q;
            end else begin
                wi_d = wi_q + 1'b1;
            end
        end
        if (rd_en) begin
            if (ri_q == LAST_IDX) begin
                full_d[rb_q] = 1'b0;
                ri_d         = '0;
                rb_d         = !rb_q;
            end else begin
                ri_d = ri_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wi_q   <= '0;
            ri_q   <= '0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wi_q   <= wi_d;
            ri_q   <= ri_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int bk = 0; bk < 2; bk++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem_q[bk][a] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wb_q][wi_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Bench for fft_reorder_buf: frame/capacity model with an expected queue,
// a table-driven single-frame check, and multi-cycle corner sequences.
module tb_fft_reorder_buf;
    localparam int W = 136;
    localparam int BR [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         out_last;

    fft_reorder_buf #(.DATA_W(W), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] part_q[$];

    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_l;

    logic         s_rdy, s_vld, s_last;
    logic [W-1:0] s_data;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_rdy;
        logic         e_vld;
        logic [W-1:0] e_data;
        logic         e_last;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check against the model, clock, update the model.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, output logic acc);
        int  nbuf;
        logic e_rdy, e_vld;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        s_rdy  = in_ready;
        s_vld  = out_valid;
        s_data = out_data;
        s_last = out_last;
        nbuf   = (exp_q.size() + 7) / 8;
        e_rdy  = (nbuf < 2);
        e_vld  = (exp_q.size() != 0);
        chk("in_ready", W'(s_rdy), W'(e_rdy));
        chk("out_valid", W'(s_vld), W'(e_vld));
        if (e_vld) begin
            chk("out_data", s_data, exp_q[0]);
            chk("out_last", W'(s_last), W'(exp_q.size() % 8 == 1));
        end else begin
            chk("out_last_idle", W'(s_last), '0);
        end
        if (hold_v) begin
            chk("hold_data", s_data, hold_d);
            chk("hold_last", W'(s_last), W'(hold_l));
        end
        acc = iv && s_rdy;
        @(posedge clk);
        if (e_vld && ordy) void'(exp_q.pop_front());
        if (iv && e_rdy) begin
            part_q.push_back(d);
            if (part_q.size() == 8) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(part_q[BR[k]]);
                part_q.delete();
            end
        end
        hold_v = s_vld && !ordy;
        hold_d = s_data;
        hold_l = s_last;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'(32'hDEAD_BEEF);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_valid", W'(out_valid), '0);
            chk("rst_out_last", W'(out_last), '0);
            chk("rst_out_data", out_data, '0);
            chk("rst_in_ready", W'(in_ready), W'(1'b1));
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        part_q.delete();
        hold_v = 1'b0;
    endtask

    task automatic stream(input int base, input int count, input bit rnd_in, input bit rnd_out,
                          input int max_cyc);
        int   v;
        int   cyc;
        logic acc, iv, ordy;
        v   = 0;
        cyc = 0;
        while ((v < count || exp_q.size() != 0) && cyc < max_cyc) begin
            iv   = (v < count) && (rnd_in ? ($urandom_range(0, 3) != 0) : 1'b1);
            ordy = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            step(iv, W'(base + v), ordy, acc);
            if (acc) v++;
            cyc++;
        end
        chk("stream_done", W'(cyc < max_cyc), W'(1'b1));
    endtask

    initial begin
        logic acc;
        int   v;
        int   cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles while in_valid is high.
        do_reset(2);

        // Single frame, table driven.
        for (int k = 0; k < 17; k++) begin
            tbl[k].iv     = (k < 8);
            tbl[k].d      = (k < 8) ? W'(k) : '0;
            tbl[k].ordy   = 1'b1;
            tbl[k].e_rdy  = 1'b1;
            tbl[k].e_vld  = (k >= 8 && k < 16);
            tbl[k].e_data = (k >= 8 && k < 16) ? W'(BR[k-8]) : '0;
            tbl[k].e_last = (k == 15);
        end
        for (int k = 0; k < 17; k++) begin
            step(tbl[k].iv, tbl[k].d, tbl[k].ordy, acc);
            chk("tbl_in_ready", W'(s_rdy), W'(tbl[k].e_rdy));
            chk("tbl_out_valid", W'(s_vld), W'(tbl[k].e_vld));
            if (tbl[k].e_vld) chk("tbl_out_data", s_data, tbl[k].e_data);
            chk("tbl_out_last", W'(s_last), W'(tbl[k].e_last));
        end

        // Backpressure: fill both banks, word 16 held until bank A drains.
        do_reset(1);
        v = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, W'(v), 1'b0, acc);
            if (acc) v++;
        end
        chk("bp_accepted", W'(v), W'(16));
        cyc = 0;
        while (v < 17 && cyc < 20) begin
            step(1'b1, W'(v), 1'b1, acc);
            if (acc) v++;
            cyc++;
        end
        chk("bp_word16_wait", W'(cyc), W'(9));
        stream(0, 0, 1'b0, 1'b0, 20);
        chk("bp_partial", W'(part_q.size()), W'(1));

        // Four back-to-back frames.
        do_reset(1);
        stream(0, 32, 1'b0, 1'b0, 60);

        // Random stalls over three frames.
        do_reset(1);
        stream(64, 24, 1'b1, 1'b1, 400);

        // Reset mid-fill and mid-drain, then a fresh frame.
        do_reset(1);
        for (int k = 0; k < 8; k++) step(1'b1, W'(200 + k), 1'b0, acc);
        for (int k = 0; k < 5; k++) step(1'b1, W'(300 + k), 1'b0, acc);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, acc);
        do_reset(1);
        stream(100, 8, 1'b0, 1'b0, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
